// File: rtl/alu_pkg.sv
// Shared types and helpers for the sliced multi-cycle ALU.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } alu_state_e;

   // Number of slice cycles needed to cover one operand.
   function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
      return width / slice;
   endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU; SUB inverts b locally so the caller only supplies cin.
module alu_slice
   import alu_pkg::*;
#(
   parameter int unsigned SLICE = 16
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   input  alu_op_e          op,
   output logic [SLICE-1:0] s,
   output logic             cout
);

   logic [SLICE-1:0] w_b_eff;
   logic [SLICE:0]   w_sum;

   always_comb begin
      w_b_eff = (op == ALU_SUB) ? ~b : b;
      w_sum   = {1'b0, a} + {1'b0, w_b_eff} + (SLICE+1)'(cin);
      s       = w_sum[SLICE-1:0];
      cout    = w_sum[SLICE];
      case (op)
         ALU_AND: begin
            s    = a & b;
            cout = 1'b0;
         end
         ALU_OR: begin
            s    = a | b;
            cout = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_sliced.sv
// Multi-cycle WIDTH-bit ALU processing SLICE bits per clock with a registered carry chain.
// Optional status flags (zero, ovf) are built only when ALU_SLICED_FLAGS_EN is defined.
module alu_sliced
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned SLICE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);

   localparam int unsigned N      = num_slices(WIDTH, SLICE);
   localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if ((WIDTH % SLICE) != 0) begin : g_width_check
      $error("alu_sliced: WIDTH must be a multiple of SLICE");
   end

   alu_state_e       r_state;
   alu_state_e       w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   alu_op_e          r_op;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic             r_in_ready;
   logic             r_out_valid;

   logic              w_accept;
   logic              w_last;
   logic [BASE_W-1:0] w_base;
   logic [SLICE-1:0]  w_slice_s;
   logic              w_slice_c;

   assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
   assign w_last   = (r_idx == IDX_W'(N - 1));
   assign w_base   = BASE_W'(32'(r_idx) * SLICE);

   alu_slice #(.SLICE(SLICE)) u_slice (
      .a    (r_a[w_base +: SLICE]),
      .b    (r_b[w_base +: SLICE]),
      .cin  (r_carry),
      .op   (r_op),
      .s    (w_slice_s),
      .cout (w_slice_c)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_op        <= ALU_ADD;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_next == IDLE);
         r_out_valid <= (w_next == DONE);
         if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= alu_op_e'(op);
            r_carry <= cin;
            r_idx   <= '0;
         end else if (r_state == RUN) begin
            r_s[w_base +: SLICE] <= w_slice_s;
            r_carry              <= w_slice_c;
            r_idx                <= r_idx + IDX_W'(1);
         end
      end
   end

`ifdef ALU_SLICED_FLAGS_EN
   logic r_zero;
   logic r_ovf;
   logic w_arith;
   logic w_b_msb;
   logic w_ovf;

   assign w_arith = (r_op == ALU_ADD) || (r_op == ALU_SUB);
   assign w_b_msb = (r_op == ALU_SUB) ? ~r_b[WIDTH-1] : r_b[WIDTH-1];
   assign w_ovf   = w_arith && (r_a[WIDTH-1] == w_b_msb) && (w_slice_s[SLICE-1] != r_a[WIDTH-1]);

   // Zero accumulates across slices; overflow is judged on the top slice only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_accept) begin
         r_zero <= 1'b1;
         r_ovf  <= 1'b0;
      end else if (r_state == RUN) begin
         r_zero <= r_zero && (w_slice_s == '0);
         if (w_last) r_ovf <= w_ovf;
      end
   end

   assign zero = r_zero;
   assign ovf  = r_ovf;
`else
   assign zero = 1'b0;
   assign ovf  = 1'b0;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign s         = r_s;
   assign cout      = r_carry;

endmodule

// File: tb/tb_alu_sliced.sv
// Directed bench for alu_sliced: 64/16 instance for the main suite, 8/8 instance for the single-slice case.
module tb_alu_sliced;

`ifdef ALU_SLICED_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, cin, out_valid, out_ready, cout, zero, ovf;
   logic [1:0]  op;
   logic [63:0] a, b, s;

   logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, zero8, ovf8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, s8;

   int checks   = 0;
   int failures = 0;

   alu_sliced #(.WIDTH(64), .SLICE(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .zero(zero), .ovf(ovf)
   );

   alu_sliced #(.WIDTH(8), .SLICE(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
      .s(s8), .cout(cout8), .zero(zero8), .ovf(ovf8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start64(input logic [1:0] o, input logic [63:0] xa, input logic [63:0] xb, input logic xc);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", 64'(in_ready), 64'd1);
      op = o; a = xa; b = xb; cin = xc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = ~xa; b = ~xb; cin = ~xc; op = ~o;
   endtask

   task automatic wait_out64(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic run64(input string tag, input logic [1:0] o, input logic [63:0] xa, input logic [63:0] xb,
                        input logic xc, input logic [63:0] es, input logic ec, input logic ez, input logic eo);
      int lat;
      start64(o, xa, xb, xc);
      wait_out64(lat);
      check({tag, "_lat"},   64'(lat), 64'd4);
      check({tag, "_s"},     s, es);
      check({tag, "_cout"},  64'(cout), 64'(ec));
      check({tag, "_zero"},  64'(zero), 64'(FLAGS & ez));
      check({tag, "_ovf"},   64'(ovf),  64'(FLAGS & eo));
      check({tag, "_rdy"},   64'(in_ready), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_vdrop"}, 64'(out_valid), 64'd0);
      check({tag, "_idle"},  64'(in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'b00;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = 2'b00;
      repeat (3) tick();
      check("rst_rdy",  64'(in_ready), 64'd0);
      check("rst_vld",  64'(out_valid), 64'd0);
      check("rst_s",    s, 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_zero", 64'(zero), 64'd0);
      check("rst_ovf",  64'(ovf), 64'd0);
      rst = 1'b0;
      tick();
      check("rel_rdy",  64'(in_ready), 64'd1);
      check("rel_rdy8", 64'(in_ready8), 64'd1);

      run64("add_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
      run64("sub_neg",  2'b01, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run64("add_ovf",  2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
      run64("sub_zero", 2'b01, 64'd9, 64'd9, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0);
      run64("add_chain", 2'b00, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
      run64("or64",     2'b11, 64'h00FF_0000_0000_1234, 64'h0F00_0000_0000_4321, 1'b1,
            64'h0FFF_0000_0000_5335, 1'b0, 1'b0, 1'b0);

      // Backpressure: result must hold and nothing new is accepted while DONE waits.
      start64(2'b00, 64'd3, 64'd4, 1'b0);
      wait_out64(lat);
      check("bp_lat", 64'(lat), 64'd4);
      in_valid = 1'b1; op = 2'b00; a = 64'd100; b = 64'd200; cin = 1'b0;
      repeat (5) begin
         tick();
         check("bp_vld", 64'(out_valid), 64'd1);
         check("bp_rdy", 64'(in_ready), 64'd0);
         check("bp_s",   s, 64'd7);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_vdrop", 64'(out_valid), 64'd0);
      check("bp_idle",  64'(in_ready), 64'd1);
      tick();
      check("bp_noacc", 64'(in_ready), 64'd1);

      // Reset two cycles into RUN abandons the operation.
      start64(2'b00, 64'h1234, 64'h1111, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("mid_rst_vld",  64'(out_valid), 64'd0);
      check("mid_rst_rdy",  64'(in_ready), 64'd0);
      check("mid_rst_s",    s, 64'd0);
      check("mid_rst_cout", 64'(cout), 64'd0);
      rst = 1'b0;
      tick();
      check("mid_rel_rdy", 64'(in_ready), 64'd1);
      run64("and_post", 2'b10, 64'hF0F0, 64'hFF00, 1'b1, 64'hF000, 1'b0, 1'b0, 1'b0);

      // Single-slice instance: result one cycle after accept.
      op8 = 2'b11; a8 = 8'hF0; b8 = 8'h0C; cin8 = 1'b0; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      a8 = 8'h00; b8 = 8'h00;
      lat = 0;
      while (!out_valid8 && lat < 20) begin
         tick();
         lat++;
      end
      check("or8_lat",  64'(lat), 64'd1);
      check("or8_s",    64'(s8), 64'hFC);
      check("or8_cout", 64'(cout8), 64'd0);
      check("or8_rdy",  64'(in_ready8), 64'd0);
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      check("or8_vdrop", 64'(out_valid8), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
